// File: rtl/linear_layer_srl_fifo_if.sv
// Write/read handshake bundle for linear_layer_srl_fifo.
// master = producer/consumer side, slave = the FIFO.
interface linear_layer_srl_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_count;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_almost_full_n, if_dout, if_empty_n, if_count
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_almost_full_n, if_dout, if_empty_n, if_count
  );
endinterface

// File: rtl/linear_layer_srl_fifo.sv
// First-word-fall-through FIFO on an addressable shift register.
// Optional macro SRL_FIFO_DOUT_MASK_EN forces if_dout to zero while empty.
module linear_layer_srl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14
) (
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  linear_layer_srl_fifo_if.slave fifo
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         next_count;
  logic                  full_n_q;
  logic                  empty_n_q;
  logic                  af_n_q;
  logic                  wr;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign wr = fifo.if_write & fifo.if_write_ce & full_n_q;
  assign rd = fifo.if_read  & fifo.if_read_ce  & empty_n_q;

  always_comb begin
    next_count = count_q;
    if (wr && !rd)
      next_count = count_q + ONE_C;
    else if (rd && !wr)
      next_count = count_q - ONE_C;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_n_q    <= 1'b1;
    end else begin
      count_q   <= next_count;
      full_n_q  <= (next_count != DEPTH_C);
      empty_n_q <= (next_count != '0);
      af_n_q    <= (next_count < AF_C);
    end
  end

  // Storage is deliberately unreset; the count alone defines which entries are live.
  always_ff @(posedge ap_clk) begin
    if (wr) begin
      for (int i = DEPTH - 1; i > 0; i--)
        storage[i] <= storage[i-1];
      storage[0] <= fifo.if_din;
    end
  end

  assign rd_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - ONE_C);

`ifdef SRL_FIFO_DOUT_MASK_EN
  assign fifo.if_dout = empty_n_q ? storage[rd_addr] : '0;
`else
  assign fifo.if_dout = storage[rd_addr];
`endif

  assign fifo.if_full_n        = full_n_q;
  assign fifo.if_empty_n       = empty_n_q;
  assign fifo.if_almost_full_n = af_n_q;
  assign fifo.if_count         = count_q;
endmodule

// File: tb/tb_linear_layer_srl_fifo.sv
// Directed, table-driven bench for linear_layer_srl_fifo (DEPTH 16, AF_LEVEL 14).
module tb_linear_layer_srl_fifo;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF_LEVEL = 14;

  typedef struct {
    bit        w;
    bit        wce;
    logic [31:0] din;
    bit        r;
    bit        rce;
    int        cnt;
    logic [31:0] dout;
    bit        chk_dout;
  } vec_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  linear_layer_srl_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ff ();

  linear_layer_srl_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .fifo    (ff.slave)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt);
    chk({tag, " count"},   32'(ff.if_count), 32'(cnt));
    chk({tag, " empty_n"}, 32'(ff.if_empty_n), 32'(cnt != 0));
    chk({tag, " full_n"},  32'(ff.if_full_n), 32'(cnt != DEPTH));
    chk({tag, " af_n"},    32'(ff.if_almost_full_n), 32'(cnt < AF_LEVEL));
  endtask

  task automatic add(input bit w, input bit wce, input logic [31:0] din,
                     input bit r, input bit rce, input int cnt,
                     input logic [31:0] dout, input bit cd);
    vec_t v;
    v.w = w; v.wce = wce; v.din = din; v.r = r; v.rce = rce;
    v.cnt = cnt; v.dout = dout; v.chk_dout = cd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    ff.if_write = 1'b0; ff.if_write_ce = 1'b0; ff.if_din = '0;
    ff.if_read = 1'b0;  ff.if_read_ce = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Fill 0x1..0x10, oldest word stays at the output
    for (int i = 1; i <= 16; i++) add(1, 1, 32'(i), 0, 0, i, 32'h1, 1);
    add(1, 1, 32'hAA, 0, 0, 16, 32'h1, 1);          // write while full ignored
    // Drain: after read j the next word shows
    for (int j = 1; j <= 15; j++) add(0, 0, 0, 1, 1, 16 - j, 32'(j + 1), 1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0);                    // read while empty ignored
    add(1, 0, 32'h99, 0, 0, 0, 0, 0);               // write without CE ignored
    add(1, 1, 32'h5, 1, 1, 1, 32'h5, 1);            // write+read on empty: write only
    add(1, 1, 32'h6, 0, 0, 2, 32'h5, 1);
    add(1, 1, 32'h7, 0, 0, 3, 32'h5, 1);
    // Simultaneous write/read at count 3
    add(1, 1, 32'h8, 1, 1, 3, 32'h6, 1);
    add(1, 1, 32'h9, 1, 1, 3, 32'h7, 1);
    add(1, 1, 32'hA, 1, 1, 3, 32'h8, 1);
    add(1, 1, 32'hB, 1, 1, 3, 32'h9, 1);
    add(0, 0, 0, 1, 1, 2, 32'hA, 1);
    add(0, 0, 0, 1, 1, 1, 32'hB, 1);
    add(0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 32'h20 + 32'(i), 0, 0, i + 1, 32'h20, 1);
    add(0, 0, 0, 1, 0, 16, 32'h20, 1);              // read without CE ignored
    add(1, 1, 32'hBB, 1, 1, 15, 32'h21, 1);         // full: only the read lands
    for (int k = 1; k <= 6; k++) add(0, 0, 0, 1, 1, 15 - k, 32'h21 + 32'(k), 1);

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk_state("reset", 0);
`ifdef SRL_FIFO_DOUT_MASK_EN
    chk("reset dout", ff.if_dout, 32'h0);
`endif

    foreach (vecs[n]) begin
      ff.if_write = vecs[n].w; ff.if_write_ce = vecs[n].wce; ff.if_din = vecs[n].din;
      ff.if_read = vecs[n].r;  ff.if_read_ce = vecs[n].rce;
      @(posedge ap_clk); #1;
      chk_state($sformatf("vec%0d", n), vecs[n].cnt);
      if (vecs[n].chk_dout) chk($sformatf("vec%0d dout", n), ff.if_dout, vecs[n].dout);
    end
    idle_inputs();

    // Asynchronous reset mid-cycle at count 9
    #2 ap_rst_n = 1'b0;
    #1 chk_state("async rst", 0);
    @(posedge ap_clk); #1;
    chk_state("in rst", 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    ff.if_write = 1'b1; ff.if_write_ce = 1'b1; ff.if_din = 32'h3C;
    @(posedge ap_clk); #1;
    idle_inputs();
    chk_state("post rst wr", 1);
    chk("post rst dout", ff.if_dout, 32'h3C);
    @(posedge ap_clk); #1;
    chk_state("post rst idle", 1);
    chk("post rst idle dout", ff.if_dout, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
